// File: rtl/alu_pkg.sv
// Shared types for the ALU share arbiter: ALU op encodings and output-buffer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   alu_op_t    - 4-bit ALU select; any encoding not listed below evaluates as ADD
//   arb_state_t - output buffer state, EMPTY (no result held) or FULL (result held)
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (module rr_arb2) with an externally held pointer.
// Latency: purely combinational, grant in the same cycle as valid.
// Backpressure: enable_i low forces no grant; the pointer holder decides when to commit.
//
// Ports:
//   valid_i[1:0]  - request lines, bit N = requester N
//   enable_i      - a grant may be issued this cycle
//   last_grant_i  - ID granted most recently (the loser of the next tie)
//   grant_o[1:0]  - one-hot grant, all-zero when nothing is granted
//   next_grant_o  - pointer value to store if this grant is accepted
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       next_grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // Tie: the requester not granted last time wins.
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Pointer only moves when something is actually granted.
  always_comb begin
    next_grant_o = last_grant_i;
    if (grant_o[1]) begin
      next_grant_o = 1'b1;
    end else if (grant_o[0]) begin
      next_grant_o = 1'b0;
    end
  end

endmodule : rr_arb2

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters; round-robin on ties, single-entry tagged result buffer.
// Latency: operation accepted in cycle N, result on res_* in cycle N+1; one op per cycle while res_ready=1.
// Backpressure: reqN_ready only when the buffer is empty or draining this cycle (combinational on res_ready).
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   reqN_valid/_ready          - requester N handshake (ready = granted this cycle)
//   reqN_a/_b/_sel             - operands and alu_op_t select for requester N
//   res_valid/_ready           - result buffer handshake
//   res_data/_zero/_id         - buffered result, zero flag, issuing requester
//   grant_cnt0/1, conflict_cnt - saturating statistics, present only when ALU_ARB_STATS_EN is defined
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Elaboration-time sanity check on the configuration.
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("alu_share_arbiter: WIDTH and CNT_W must be at least 1");
  end

  arb_state_t       state_q;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             arb_en;
  logic [1:0]       grant;
  logic             grant_any;
  logic             both_valid;

  alu_op_t          op_sel;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_y;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Drain-and-refill: a full buffer that is being read this cycle can take a
  // new result in the same cycle.
  assign can_accept = (state_q == EMPTY) || res_ready;
  // rst_n gates the grant so an in-flight handshake is dropped the moment
  // reset asserts, not at the next clock edge.
  assign arb_en     = can_accept && rst_n;
  assign both_valid = req0_valid && req1_valid;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({req1_valid, req0_valid}),
    .enable_i     (arb_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .next_grant_o (last_grant_d)
  );

  assign grant_any  = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // ---------------------------------------------------------------------------
  // Shared ALU: operand mux on the grant, then one combinational evaluation.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_sel = alu_op_t'(req0_sel);
    if (grant[1]) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_sel = alu_op_t'(req1_sel);
    end
  end

  always_comb begin
    unique case (op_sel)
      ALU_AND: alu_y = op_a & op_b;
      ALU_OR:  alu_y = op_a | op_b;
      ALU_SUB: alu_y = op_a - op_b;
      // ALU_ADD and every unlisted encoding; carry out is dropped.
      default: alu_y = op_a + op_b;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    if (grant_any) begin
      res_data_d = alu_y;
      res_id_d   = grant[1];
    end
  end

  // Buffer FSM plus the registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      // Pointer starts at 1 so requester 0 wins the first tie.
      last_grant_q <= 1'b1;
    end else begin
      if (state_q == EMPTY) begin
        if (grant_any) begin
          state_q <= FULL;
        end
      end else begin
        if (res_ready && !grant_any) begin
          state_q <= EMPTY;
        end
      end
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  // Derived from the stored result; reset value of 0 gives res_zero=1.
  assign res_zero  = (res_data_q == '0);

  // ---------------------------------------------------------------------------
  // Optional statistics, saturating at all-ones.
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (grant[0] && (grant_cnt0_q != '1)) begin
        grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
      end
      if (grant[1] && (grant_cnt1_q != '1)) begin
        grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
      end
      if (both_valid && grant_any && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`else
  // Tie-detect is only consumed by the statistics block.
  logic unused_both_valid;
  assign unused_both_valid = both_valid;
`endif

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, reset corner cases,
// randomized traffic against a behavioural model, and (with ALU_ARB_STATS_EN) counter saturation.
module tb_alu_share_arbiter;

  localparam int W = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          v0, v1, rr;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [3:0]    s0, s1;
  logic          r0, r1;
  logic          rv, rz, rid;
  logic [W-1:0]  rdata;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] gc0, gc1, cfc;
`endif

  alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v0),
    .req0_ready (r0),
    .req0_a     (a0),
    .req0_b     (b0),
    .req0_sel   (s0),
    .req1_valid (v1),
    .req1_ready (r1),
    .req1_a     (a1),
    .req1_b     (b1),
    .req1_sel   (s1),
    .res_valid  (rv),
    .res_ready  (rr),
    .res_data   (rdata),
    .res_zero   (rz),
    .res_id     (rid)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0   (gc0),
    .grant_cnt1   (gc1),
    .conflict_cnt (cfc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Holds what a consumer would see: whether a result is pending, its value and owner,
  // and who won the previous tie-capable grant.
  logic         m_full;
  logic [W-1:0] m_data;
  logic         m_id;
  logic         m_last;

  function automatic logic [W-1:0] ref_alu(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (s == 4'd0) return a & b;
    if (s == 4'd1) return a | b;
    if (s == 4'd6) return a - b;
    return a + b;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_id   = 1'b0;
    m_last = 1'b1;
  endtask

  // Returns -1 for no grant, otherwise the granted requester.
  function automatic int model_grant();
    if (m_full && !rr) return -1;
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_clock(input int g);
    if (g == 0) begin
      m_data = ref_alu(s0, a0, b0); m_id = 1'b0; m_full = 1'b1; m_last = 1'b0;
    end else if (g == 1) begin
      m_data = ref_alu(s1, a1, b1); m_id = 1'b1; m_full = 1'b1; m_last = 1'b1;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endtask

  // ---------------- directed vector table ----------------
  // Expected res_* fields are what is visible during the cycle the inputs are applied.
  typedef struct {
    logic         v0, v1, rr;
    logic [W-1:0] a0, b0;
    logic [3:0]   s0;
    logic [W-1:0] a1, b1;
    logic [3:0]   s1;
    logic         e_r0, e_r1, e_rv;
    logic [W-1:0] e_data;
    logic         e_id, e_zero;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // req0 ADD 5+3 alone
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'd5, 32'd3, 4'b0010, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    // conflicts: req0 SUB 7-7, req1 OR F0|0F; pointer now favours req1
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'd7, 32'd7, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b1, 1'b1, 32'd8, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'd7, 32'd7, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hFF, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'd7, 32'd7, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'd7, 32'd7, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hFF, 1'b1, 1'b0};
    // consumer stalls 3 cycles, req1 waits
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 4'b0000, 32'hF0, 32'h0F, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1};
    // unlisted select -> ADD wraps to zero
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b1111, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 32'hFF, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    // drain with nothing to refill -> empty
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
  end

  logic [3:0] sel_pool [4];

  initial begin
    int g;
    sel_pool[0] = 4'b0000; sel_pool[1] = 4'b0001; sel_pool[2] = 4'b0010; sel_pool[3] = 4'b0110;

    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; s0 = '0; s1 = '0;
    model_reset();

    // ---- reset state, valids high during reset must not be granted ----
    repeat (2) @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    #1;
    check("rst_res_valid", W'(rv), W'(0));
    check("rst_res_data", rdata, W'(0));
    check("rst_res_zero", W'(rz), W'(1));
    check("rst_res_id", W'(rid), W'(0));
    check("rst_req0_ready", W'(r0), W'(0));
    check("rst_req1_ready", W'(r1), W'(0));
    rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      v0 = vecs[i].v0; v1 = vecs[i].v1; rr = vecs[i].rr;
      a0 = vecs[i].a0; b0 = vecs[i].b0; s0 = vecs[i].s0;
      a1 = vecs[i].a1; b1 = vecs[i].b1; s1 = vecs[i].s1;
      #1;
      check($sformatf("vec%0d_req0_ready", i), W'(r0), W'(vecs[i].e_r0));
      check($sformatf("vec%0d_req1_ready", i), W'(r1), W'(vecs[i].e_r1));
      check($sformatf("vec%0d_res_valid", i), W'(rv), W'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        check($sformatf("vec%0d_res_data", i), rdata, vecs[i].e_data);
        check($sformatf("vec%0d_res_id", i), W'(rid), W'(vecs[i].e_id));
        check($sformatf("vec%0d_res_zero", i), W'(rz), W'(vecs[i].e_zero));
      end
      @(negedge clk);
    end

    // ---- reset while FULL, then first conflict goes to requester 0 ----
    v0 = 1'b0; v1 = 1'b1; rr = 1'b1;
    a1 = 32'd1; b1 = 32'd1; s1 = 4'b0010;
    @(negedge clk);
    v1 = 1'b0;
    #1;
    check("pre_rst_res_valid", W'(rv), W'(1));
    check("pre_rst_res_data", rdata, W'(2));
    v0 = 1'b1; v1 = 1'b1; a0 = 32'd9; b0 = 32'd4; s0 = 4'b0110;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", W'(rv), W'(0));
    check("midrst_res_data", rdata, W'(0));
    check("midrst_req0_ready", W'(r0), W'(0));
    check("midrst_req1_ready", W'(r1), W'(0));
    rst_n = 1'b1;
    #1;
    check("postrst_req0_ready", W'(r0), W'(1));
    check("postrst_req1_ready", W'(r1), W'(0));
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    check("postrst_res_valid", W'(rv), W'(1));
    check("postrst_res_id", W'(rid), W'(0));
    check("postrst_res_data", rdata, W'(5));
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      s0 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : sel_pool[$urandom_range(0, 3)];
      s1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : sel_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst_res_valid", W'(rv), W'(0));
        check("rnd_rst_req0_ready", W'(r0), W'(0));
        check("rnd_rst_req1_ready", W'(r1), W'(0));
        rst_n = 1'b1;
        model_reset();
      end
      #1;
      g = model_grant();
      check("rnd_req0_ready", W'(r0), W'(g == 0));
      check("rnd_req1_ready", W'(r1), W'(g == 1));
      check("rnd_res_valid", W'(rv), W'(m_full));
      if (m_full) begin
        check("rnd_res_data", rdata, m_data);
        check("rnd_res_id", W'(rid), W'(m_id));
        check("rnd_res_zero", W'(rz), W'(m_data == '0));
      end
      model_clock(g);
      @(negedge clk);
    end

`ifdef ALU_ARB_STATS_EN
    // ---- counters: 20 back-to-back conflicts ----
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("stats_rst_grant_cnt0", W'(gc0), W'(0));
    check("stats_rst_conflict_cnt", W'(cfc), W'(0));
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    repeat (20) @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    check("stats_conflict_cnt", W'(cfc), W'(15));
    check("stats_grant_cnt0", W'(gc0), W'(10));
    check("stats_grant_cnt1", W'(gc1), W'(10));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_share_arbiter
